// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional feature macro used by the top: FETCH_BYPASS_EN.
package if_pkg;

  localparam int XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), available to consumers that
  // need a filler instruction when the queue has nothing to offer.
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // Sequential fetch stride in bytes.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // One buffered fetch result: the address it came from and the word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push, pop, flush and an occupancy count.
// Storage is not reset; only pointers and count are. The head word is
// read straight from storage, so consumers must qualify it with count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_C) return '0;
    return p + 1'b1;
  endfunction

  // Next-state for pointers and count; flush empties the queue outright.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a push in a flush cycle is dropped with the rest.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue ahead of IF/ID. Issues sequential fetches,
// tracks in-flight requests, discards responses made stale by a redirect
// and buffers the rest for the IF/ID handshake.
// Optional build macro FETCH_BYPASS_EN: forward a response straight to the
// output when the queue is empty and the consumer is ready.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int TW = $clog2(MAX_OUTST) + 1;
  localparam logic [CW-1:0] MAX_OUTST_C = CW'(MAX_OUTST);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S     = SW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            req_en_q, req_en_d;

  logic [SW-1:0]   credit_sum;
  logic            req_fire;
  logic            resp_discard;
  logic            bypass_hit;
  logic            fifo_valid;

  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            data_push, data_pop;
  logic [CW-1:0]   data_count;

  logic [XLEN-1:0] trk_head;
  logic [TW-1:0]   trk_count;

  // Buffered {pc, inst} results waiting for IF/ID.
  fetch_fifo #(.DEPTH(DEPTH), .W(2 * XLEN)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_push),
    .push_data (push_entry),
    .pop       (data_pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (data_count)
  );

  // Address of each accepted request, popped as its response returns, so
  // the head is always the pc belonging to the response on the bus.
  fetch_fifo #(.DEPTH(MAX_OUTST), .W(XLEN)) u_pc_tracker (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_resp_valid),
    .flush     (1'b0),
    .head      (trk_head),
    .count     (trk_count)
  );

  // Zero-latency forwarding is only safe with nothing queued ahead of it.
`ifdef FETCH_BYPASS_EN
  assign bypass_hit = imem_resp_valid && (data_count == '0) && (drop_q == '0)
                      && !redirect_valid && out_ready;
`else
  assign bypass_hit = 1'b0;
`endif

  // Request credit: never have more words coming than the queue can hold.
  always_comb begin
    credit_sum     = SW'(data_count) + SW'(outst_q) - SW'(drop_q);
    imem_req_valid = req_en_q && !redirect_valid && (outst_q < MAX_OUTST_C)
                     && (credit_sum < DEPTH_S);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // Response routing: stale or redirect-cycle responses are thrown away.
  always_comb begin
    resp_discard = imem_resp_valid && (redirect_valid || (drop_q != '0));
    push_entry   = '{pc: trk_head, inst: imem_resp_data};
    data_push    = imem_resp_valid && !resp_discard && !bypass_hit;
    fifo_valid   = (data_count != '0);
    data_pop     = fifo_valid && out_ready;
  end

  // Output view of the queue head, or of the forwarded response.
  always_comb begin
    out_valid = fifo_valid;
    out_pc    = fifo_valid ? head_entry.pc : '0;
    out_inst  = fifo_valid ? head_entry.inst : '0;
    if (bypass_hit) begin
      out_valid = 1'b1;
      out_pc    = trk_head;
      out_inst  = imem_resp_data;
    end
    occupancy = data_count;
  end

  // Fetch pc and in-flight bookkeeping; a redirect marks everything still
  // outstanding after this cycle as to-be-dropped.
  always_comb begin
    req_en_d   = 1'b1;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    case ({req_fire, imem_resp_valid})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_d     = outst_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  // Control registers; the request enable holds off fetching until the
  // first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_en_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      req_en_q   <= req_en_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Invariants of the credit scheme.
  assert property (@(posedge clk) disable iff (!rst)
    !(data_push && (data_count == DEPTH_C) && !data_pop));
  assert property (@(posedge clk) disable iff (!rst)
    (CW'(trk_count) == outst_q));
  assert property (@(posedge clk) disable iff (!rst)
    !(imem_resp_valid && (outst_q == '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a cycle table for streaming and
// back-pressure, then hand-written redirect and latency sequences.
module tb_if_prefetch_queue;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  occupancy;

  if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  typedef struct {
    bit          ordy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_occ;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  int          lat    = 1;
  pend_t       pend_q[$];
  logic [31:0] deliv_q[$];
  vec_t        tbl[32];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input bit o, input bit r, input int a,
                              input bit v, input int pc, input int occ);
    vec_t t;
    t.ordy = o; t.e_req = r; t.e_addr = a; t.e_ov = v; t.e_pc = pc; t.e_occ = occ;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, model the IMEM,
  // record delivered pcs and check the delivered instruction word.
  task automatic tick(input bit ordy, input bit redir, input logic [31:0] rpc);
    pend_t p;
    @(negedge clk);
    cyc++;
    out_ready       = ordy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(p.addr);
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      p.due  = cyc + lat;
      p.addr = imem_req_addr;
      pend_q.push_back(p);
    end
    if (out_valid && out_ready) begin
      deliv_q.push_back(out_pc);
      check("out_inst", out_inst, inst_of(out_pc));
    end
  endtask

  task automatic do_reset(input int l);
    rst             = 1'b0;
    lat             = l;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    pend_q.delete();
    deliv_q.delete();
    #2;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_occupancy", {29'b0, occupancy}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    #1;
    check("req_at_release", {31'b0, imem_req_valid}, 32'd0);
  endtask

  // Run with out_ready=1 until n words are delivered after a redirect,
  // expecting base, base+4, ... and optionally that the first request
  // issued goes to base.
  task automatic run_collect(input int n, input logic [31:0] base, input bit chk_req);
    bit seen = 1'b0;
    int k = 0;
    while (deliv_q.size() < n && k < 60) begin
      tick(1'b1, 1'b0, '0);
      k++;
      if (chk_req && !seen && imem_req_valid) begin
        seen = 1'b1;
        check("first_req_addr", imem_req_addr, base);
      end
    end
    check("deliv_count", deliv_q.size(), n);
    for (int i = 0; i < n && i < deliv_q.size(); i++)
      check("deliv_pc", deliv_q[i], base + 32'(4 * i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming then 20 stalled cycles then release, IMEM latency 1.
    tbl[0] = mk(1, 1,  0, 0,  0, 0);
    tbl[1] = mk(1, 1,  4, 0,  0, 0);
    tbl[2] = mk(1, 1,  8, 1,  0, 1);
    tbl[3] = mk(1, 1, 12, 1,  4, 1);
    tbl[4] = mk(1, 1, 16, 1,  8, 1);
    tbl[5] = mk(1, 1, 20, 1, 12, 1);
    tbl[6] = mk(0, 1, 24, 1, 16, 1);
    tbl[7] = mk(0, 1, 28, 1, 16, 2);
    tbl[8] = mk(0, 0,  0, 1, 16, 3);
    for (int k = 9; k < 26; k++) tbl[k] = mk(0, 0, 0, 1, 16, 4);
    tbl[26] = mk(1, 0,  0, 1, 16, 4);
    tbl[27] = mk(1, 1, 32, 1, 20, 3);
    tbl[28] = mk(1, 1, 36, 1, 24, 2);
    tbl[29] = mk(1, 1, 40, 1, 28, 2);
    tbl[30] = mk(1, 1, 44, 1, 32, 2);
    tbl[31] = mk(1, 1, 48, 1, 36, 2);

`ifndef FETCH_BYPASS_EN
    do_reset(1);
    for (int i = 0; i < 32; i++) begin
      tick(tbl[i].ordy, 1'b0, '0);
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) check("req_addr", imem_req_addr, tbl[i].e_addr);
      check("out_valid", {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
      if (tbl[i].e_ov) check("out_pc", out_pc, tbl[i].e_pc);
      check("occupancy", {29'b0, occupancy}, tbl[i].e_occ);
    end
    check("stream_count", deliv_q.size(), 10);
    for (int i = 0; i < 10 && i < deliv_q.size(); i++)
      check("stream_pc", deliv_q[i], 32'(4 * i));
`endif

    // Latency 3, redirect with two requests in flight: both discarded.
    do_reset(3);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h100);
    check("redir_req_off", {31'b0, imem_req_valid}, 32'd0);
    check("redir_none_yet", deliv_q.size(), 0);
    deliv_q.delete();
    run_collect(3, 32'h100, 1'b1);

    // Latency 2, redirect while a response arrives and the head is taken.
    do_reset(2);
    repeat (5) tick(1'b0, 1'b0, '0);
    check("pre_redir_occ", {29'b0, occupancy}, 32'd2);
    tick(1'b1, 1'b1, 32'h400);
    check("redir_out_valid", {31'b0, out_valid}, 32'd1);
    check("redir_out_pc", out_pc, 32'h0);
    check("redir_req_off2", {31'b0, imem_req_valid}, 32'd0);
    deliv_q.delete();
    tick(1'b1, 1'b0, '0);
    check("flush_occ", {29'b0, occupancy}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_redir_req", {31'b0, imem_req_valid}, 32'd1);
    check("post_redir_addr", imem_req_addr, 32'h400);
    run_collect(2, 32'h400, 1'b0);

    // Back-to-back redirects: the second target wins.
    do_reset(2);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h200);
    check("b2b_req_off_a", {31'b0, imem_req_valid}, 32'd0);
    tick(1'b1, 1'b1, 32'h300);
    check("b2b_req_off_b", {31'b0, imem_req_valid}, 32'd0);
    check("b2b_none_yet", deliv_q.size(), 0);
    deliv_q.delete();
    run_collect(3, 32'h300, 1'b1);

    // Empty-queue response latency.
    do_reset(1);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
`ifdef FETCH_BYPASS_EN
    check("bypass_out_valid", {31'b0, out_valid}, 32'd1);
    check("bypass_out_pc", out_pc, 32'h0);
    check("bypass_occ", {29'b0, occupancy}, 32'd0);
`else
    check("lat_out_valid_n", {31'b0, out_valid}, 32'd0);
    tick(1'b1, 1'b0, '0);
    check("lat_out_valid_n1", {31'b0, out_valid}, 32'd1);
    check("lat_out_pc_n1", out_pc, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
